// File: rtl/adam_clk_ctrl.sv
// rtl/adam_clk_ctrl.sv - runtime controller for a glitch-free programmable clock divider
module adam_clk_ctrl #(
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_ready,
    output logic             out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] active_div
);

    localparam int GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GATE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [GCW-1:0]   gcnt_q, gcnt_d;
    logic [WIDTH-1:0] active_div_q, active_div_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pend_valid_q, pend_valid_d;
    // An IDLE accept parks the value in pending_q and applies it one edge later.
    logic             load_q, load_d;

    logic accept;
    logic toggle;

    assign div_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign busy       = (state_q == ST_DRAIN) || (state_q == ST_GATE);
    assign out        = out_q;
    assign tick       = tick_q;
    assign active_div = active_div_q;

    assign accept = div_valid && div_ready;
    assign toggle = (cnt_q == active_div_q);

    // Next-state logic: divide counter, ratio handshake and the drain/gate sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        gcnt_d       = gcnt_q;
        active_div_d = active_div_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        load_d       = 1'b0;

        if (load_q) begin
            active_div_d = pending_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (accept) begin
                    pending_d = div_value;
                    load_d    = 1'b1;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (toggle) begin
                    out_d = ~out_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (accept || !en) begin
                    if (accept) begin
                        pending_d    = div_value;
                        pend_valid_d = 1'b1;
                    end
                    if (out_q && !toggle) begin
                        // High phase still running: let it finish at the old ratio.
                        state_d = ST_DRAIN;
                    end else if (out_q || accept) begin
                        // Either falling right now or already low: hold low and gate.
                        state_d = ST_GATE;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                        gcnt_d  = '0;
                    end else begin
                        // Plain stop while low: a rising toggle is suppressed.
                        state_d = ST_IDLE;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (toggle) begin
                    out_d   = 1'b0;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    state_d = ST_GATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GATE: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (gcnt_q == GATE_LAST) begin
                    gcnt_d = '0;
                    if (pend_valid_q) begin
                        active_div_d = pending_q;
                        pend_valid_d = 1'b0;
                    end
                    state_d = en ? ST_RUN : ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        tick_d = out_d && !out_q;
    end

    // State registers; reset discards everything, including a pending ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_q        <= 1'b0;
            tick_q       <= 1'b0;
            gcnt_q       <= '0;
            active_div_q <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            tick_q       <= tick_d;
            gcnt_q       <= gcnt_d;
            active_div_q <= active_div_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            load_q       <= load_d;
        end
    end

endmodule

// File: doc/adam_clk_ctrl.md
# adam_clk_ctrl

Runtime controller for a programmable clock divider. It owns the divide counter and the divided-clock flop, accepts new divide ratios through a valid/ready handshake, and applies them glitch-free. A ratio change waits for a low phase, holds the output low for a fixed quiet window, then resumes at the new ratio. It sits between the system control registers and the peripheral clock domains that consume `out` and `tick`.

## Interface
- `WIDTH`, 8, width of the divide value.
- `GATE_CYCLES`, 2, number of `clk` cycles that `out` is held low between an old and a new ratio. Must be ≥ 1.

- `clk` in 1: source clock. All state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run request. 1 = produce a clock; 0 = park `out` low.
- `div_valid` in 1: a new divide value is offered.
- `div_value` in WIDTH: the requested divide value D.
- `div_ready` out 1: the controller can accept `div_value`.
- `out` out 1: divided clock. Driven directly from a flop.
- `tick` out 1: one-cycle pulse, asserted in the cycle in which `out` is 1 for the first time after a rising edge.
- `busy` out 1: asserted when a ratio change or a stop is in progress.
- `active_div` out WIDTH: the divide value currently in use.

## Operation
- Divide rule: `out` toggles when `cnt == active_div`, and `cnt` returns to 0 at that point. Otherwise `cnt` increments. Period = 2·(D+1) `clk` cycles, duty cycle 50 %. D = 0 gives clk/2. The counter never wraps past D.
- A handshake completes in a cycle where `div_valid` and `div_ready` are both 1 at the rising edge.
- States:
  - **IDLE**: `out` = 0 and `cnt` = 0.
    - `div_ready` = 1.
    - An accepted value loads `active_div` on the next edge; the state stays IDLE.
    - `en` = 1 → go to RUN with `cnt` = 0.
  - **RUN**: counting.
    - `div_ready` = 1.
    - On an accepted value, latch it into `pending`.
      - If `out` = 1 → go to DRAIN.
      - If `out` = 0 → go to GATE.
    - `en` = 0 with no accept:
      - If `out` = 1 → go to DRAIN.
      - If `out` = 0 → go to IDLE with `cnt` = 0.
  - **DRAIN**: counting continues at the old ratio until the falling toggle. On the edge that drives `out` to 0, go to GATE with `cnt` cleared.
    - `div_ready` = 0.
    - `busy` = 1.
  - **GATE**: `out` = 0 and a gate counter runs for GATE_CYCLES cycles.
    - `div_ready` = 0.
    - `busy` = 1.
    - On the last cycle:
      - If a value is pending, load it into `active_div`.
      - Then, if `en` = 1 → go to RUN with `cnt` = 0; otherwise → go to IDLE.
    - A stop request with no pending value also passes through GATE.
- Simultaneous events:
  - `en` falling while in DRAIN or GATE: the pending load still completes, and the block ends in IDLE.
  - `en` falling in the same cycle as an accept in RUN: the value is accepted, loaded after GATE, and the block ends in IDLE.
  - `en` rising again while in GATE: the block resumes RUN at the end of GATE.
- Glitch-freeness guarantees:
  - No high phase is ever shortened.
  - Every low phase across a transition is at least GATE_CYCLES cycles.
  - `out` never changes other than by a counter toggle or by being held low.

## Timing
- Values held while `rst_n` is asserted:
  - state = IDLE
  - `out` = 0
  - `tick` = 0
  - `cnt` = 0
  - `active_div` = 0
  - `pending` = 0
  - `busy` = 0
  - `div_ready` = 1
- Reset assertion is asynchronous. It clears all state immediately, including in the middle of a DRAIN or GATE, and any pending value is discarded.
- Start latency: `en` is sampled high in IDLE at edge k. Then `out` rises at edge k + D + 1, and `tick` is high during the cycle after edge k + D + 1.
- IDLE load: `active_div` is updated on the edge that follows the accepting edge.
- `div_ready` falls in the cycle after an accept in RUN. It returns to 1 on the same edge that enters RUN or IDLE from GATE.
- `busy` = 1 exactly while the state is DRAIN or GATE.

## Test plan
- Reset, then `en` = 1 with `active_div` = 0 → `out` toggles every cycle (period 2). `tick` is high every second cycle. `div_ready` = 1 throughout.
- In IDLE, accept D = 3, then `en` = 1 at edge k → `out` rises at edge k+4, with period 8 and duty cycle 4/4. `tick` gives one pulse per period.
- RUN at D = 3, accept D = 1 while `out` = 1 after 1 high cycle → DRAIN for 3 more high cycles, then `out` low for GATE_CYCLES = 2 cycles. Then `active_div` = 1, the next high phase lasts 2 cycles after a 2-cycle low, and `busy` is high from the accept until RUN is re-entered.
- RUN at D = 2, `en` drops while `out` = 1 → the high phase completes at its full length of 3 cycles, then GATE, then IDLE with `out` = 0. Next, `en` = 1 → the restart latency is 3 cycles.
- Accept a value in the same cycle `en` falls, then raise `en` during GATE → the new ratio is loaded and RUN resumes at the end of GATE. No output high pulse shorter than D + 1 cycles is ever observed.
- Assert `rst_n` = 0 during GATE with a value pending → `out` = 0 and `active_div` = 0 immediately. After release, the pending value has been discarded and `div_ready` = 1.
